// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   ADD_WIDTH    default operand/result width
//   MAX_STAGES   deepest supported pipeline
//   stage_ctl_t  control part of a stage record; the data part (a, b', partial
//                sum) is WIDTH bits per field and lives in the top as arrays
//   stages_legal elaboration-time parameter check
package pipelined_adder_pkg;

  localparam int unsigned ADD_WIDTH  = 32;
  localparam int unsigned MAX_STAGES = 4;

  // carry: carry into this stage's slice (stage 0: the subtract carry-in)
  typedef struct packed {
    logic valid;
    logic sub;
    logic carry;
  } stage_ctl_t;

  function automatic bit stages_legal(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= MAX_STAGES) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// One W-bit slice of the carry chain.
//   a, b   slice operands (b already inverted for subtract)
//   cin    carry into bit 0 of the slice
//   sum    slice sum
//   cout   carry out of the slice MSB
//   c_msb  carry into the slice MSB (used for signed overflow on the top slice)
module adder_slice
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned W = ADD_WIDTH / 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum   = full[W-1:0];
  assign cout  = full[W];
  // sum MSB = a ^ b ^ carry_in, so the carry into the MSB falls out of an XOR
  assign c_msb = full[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor, one carry-chained slice per cycle.
//   clk_i, rst_i             clock and synchronous active-high reset
//   in_valid_i / in_ready_o  operand handshake (in_ready_o is combinational)
//   src1_i, src2_i, sub_i    operands and mode (1: src1 - src2)
//   out_valid_o / out_ready_i result handshake
//   sum_o, carry_o, overflow_o registered result and flags
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = ADD_WIDTH,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int unsigned WS = WIDTH / STAGES;

  if (!stages_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must divide by STAGES and STAGES must be 1..4");
  end

  // stage k holds an op waiting for slice k to be added
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] psum_q [STAGES];
  stage_ctl_t       ctl_q  [STAGES];

  logic [WS-1:0]    slice_sum  [STAGES];
  logic             slice_cout [STAGES];
  logic             slice_cmsb [STAGES];
  logic [WIDTH-1:0] merged     [STAGES];
  logic             advance;

  // Global stall: the whole pipe moves only when the output slot can take a value
  assign advance    = !out_valid_o || out_ready_i;
  assign in_ready_o = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(.W(WS)) u_slice (
      .a     (a_q[k][k*WS +: WS]),
      .b     (b_q[k][k*WS +: WS]),
      .cin   (ctl_q[k].carry),
      .sum   (slice_sum[k]),
      .cout  (slice_cout[k]),
      .c_msb (slice_cmsb[k])
    );
  end

  // Partial sum after this stage: completed lower bits plus this stage's slice
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      merged[k] = psum_q[k];
      merged[k][k*WS +: WS] = slice_sum[k];
    end
  end

  // Stage registers and output registers; bubbles shift along with real ops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= '0;
      end
      out_valid_o <= 1'b0;
      sum_o       <= '0;
      carry_o     <= 1'b0;
      overflow_o  <= 1'b0;
    end else if (advance) begin
      a_q[0]       <= src1_i;
      b_q[0]       <= sub_i ? ~src2_i : src2_i;
      psum_q[0]    <= '0;
      ctl_q[0]     <= '{valid: in_valid_i, sub: sub_i, carry: sub_i};
      for (int k = 1; k < STAGES; k++) begin
        a_q[k]    <= a_q[k-1];
        b_q[k]    <= b_q[k-1];
        psum_q[k] <= merged[k-1];
        ctl_q[k]  <= '{valid: ctl_q[k-1].valid, sub: ctl_q[k-1].sub, carry: slice_cout[k-1]};
      end
      out_valid_o <= ctl_q[STAGES-1].valid;
      sum_o       <= merged[STAGES-1];
      carry_o     <= slice_cout[STAGES-1];
      overflow_o  <= slice_cmsb[STAGES-1] ^ slice_cout[STAGES-1];
    end
  end

endmodule
